phase_request_scheduler: RTL and testbench
==========================================

Name: phase_request_scheduler

Overview:
- Upstream stage of the per-PLL phase_shift_processor instances.
- Accepts absolute target-phase requests per PLL and tracks each PLL's current phase.
- Computes the forward step count, modulo one full rotation, and drives the processor's ready / periods / PLL-select inputs.
- Sequences one shift at a time and watches the processor state to detect start and completion.

Parameters:
- NUM_PLLS, 2, number of PLLs served; index width PLL_W = max(1, clog2(NUM_PLLS)).
- PHASE_W, 8, width of phase and step-count values.
- PHASE_STEPS, 64, phase steps per full VCO rotation; must satisfy 2 ≤ PHASE_STEPS ≤ 2^PHASE_W.
- START_TIMEOUT, 16, cycles to wait for the processor to leave LISTEN after a ready pulse.

Ports:
- i_clk  in  1  clock; all logic posedge. The processor samples on negedge, so outputs are stable half a cycle before use.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- i_req_pll  in  PLL_W  target PLL index.
- i_req_phase  in  PHASE_W  absolute target phase, 0..PHASE_STEPS-1.
- o_req_ready  out  1  scheduler can accept a request this cycle.
- o_periods_to_process  out  PHASE_W  step count driven to the processor.
- o_pll_to_update  out  PLL_W  PLL select driven to the processor.
- o_ready  out  1  start strobe to the processor.
- i_shift_state  in  3  o_current_state of the selected processor.
- o_busy  out  1  scheduler not IDLE.
- o_err_timeout  out  1  sticky: processor never started.
- o_err_range  out  1  sticky: request phase ≥ PHASE_STEPS.
- o_cur_phase_flat  out  NUM_PLLS*PHASE_W  current-phase table, PLL0 in the LSBs.

Behaviour:
- Reset values (async on i_rst_n low):
  - state IDLE; phase table all 0.
  - o_req_ready=1; o_ready=0; o_periods_to_process=0; o_pll_to_update=0.
  - o_busy=0; both error flags 0.
- States: IDLE, CALC, ISSUE, WAIT_START, WAIT_DONE.
- IDLE, accept (i_req_valid & o_req_ready):
  - Latch pll and phase; go CALC.
  - o_req_ready=1 only in IDLE.
- IDLE, range check at accept:
  - If i_req_phase ≥ PHASE_STEPS, or i_req_pll ≥ NUM_PLLS: set o_err_range, drop the request, stay IDLE.
- CALC:
  - delta = (target − cur[pll]) mod PHASE_STEPS, computed in PHASE_W+1 bits: add PHASE_STEPS if negative.
  - delta==0: no shift; return to IDLE next cycle, table unchanged.
  - Otherwise latch o_periods_to_process=delta and o_pll_to_update=pll; go ISSUE.
- ISSUE:
  - o_ready=1 for 2 consecutive cycles, so at least one processor negedge sees it. Then deassert; go WAIT_START.
  - o_periods_to_process and o_pll_to_update are held constant from CALC exit until WAIT_DONE exits.
- WAIT_START:
  - A timeout counter starts at 0 and counts cycles.
  - i_shift_state ≠ LISTEN (000) → go WAIT_DONE.
  - Counter reaches START_TIMEOUT → set o_err_timeout, table unchanged, go IDLE.
- WAIT_DONE:
  - The processor sequence is SHIFT → VALIDATE → RESET → LISTEN.
  - On observing RESET (100), then LISTEN: set cur[pll] = target; go IDLE.
  - No timeout here; shifts can take arbitrarily long.
- Wrap-around: target < cur yields a forward rotation (e.g. cur=60, target=4, PHASE_STEPS=64 → delta=8).
- Error flags: sticky until reset; they do not block further requests.
- Simultaneous events: a request arriving while not IDLE is not accepted (o_req_ready=0); the requester holds it.
- Reset mid-operation: everything returns to reset values immediately; the phase table clears to 0. Software must re-align the PLLs after reset.
- o_busy = (state ≠ IDLE).

Decomposition:
- Shared package phase_shift_pkg:
  - processor state codes: LISTEN=3'b000, SHIFT=3'b001, VALIDATE=3'b010, RESET=3'b100;
  - scheduler state encoding;
  - default PHASE_STEPS.
  - phase_shift_processor adopts the same constants.
- One natural sub-module: phase_delta_calc, combinational modular subtract (cur, target → delta, zero flag), unit-tested separately.

Test Plan:
- Basic shift:
  - Stimulus: PLL0 cur=0, request phase 5; bench processor model: LISTEN→SHIFT after ready, RESET then LISTEN after 5 steps.
  - Required: o_periods_to_process=5, o_pll_to_update=0, o_ready high exactly 2 cycles, cur[0]=5 after done, o_req_ready returns to 1.
- Wrap-around:
  - Stimulus: PLL1 cur=60, request 4, PHASE_STEPS=64.
  - Required: delta=8 issued with o_pll_to_update=1; afterwards cur[1]=4 and cur[0] unchanged.
- Zero delta:
  - Stimulus: request phase equal to the current phase.
  - Required: no o_ready pulse; IDLE within 2 cycles of accept; table unchanged.
- Timeout:
  - Stimulus: processor model held in LISTEN.
  - Required: o_err_timeout=1 exactly START_TIMEOUT cycles after WAIT_START entry; table unchanged; next request accepted normally.
- Range error:
  - Stimulus: request phase 70 (PHASE_STEPS=64).
  - Required: o_err_range=1, no issue, o_req_ready stays 1.
- Reset mid-shift:
  - Stimulus: assert i_rst_n=0 during WAIT_DONE.
  - Required: outputs at reset values immediately (asynchronously); table all 0; o_ready=0.

Source files
------------

// File: rtl/phase_shift_pkg.sv
// Shared constants for the phase-shift path: processor state codes, scheduler
// state encoding and the default rotation size.
package phase_shift_pkg;

    typedef enum logic [2:0] {
        PS_LISTEN   = 3'b000,
        PS_SHIFT    = 3'b001,
        PS_VALIDATE = 3'b010,
        PS_RESET    = 3'b100
    } proc_state_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CALC       = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4
    } sched_state_e;

    localparam int DEFAULT_PHASE_STEPS = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_request_scheduler_if.sv
// Request handshake between a phase requester (master) and the scheduler (slave).
interface phase_request_scheduler_if #(
    parameter int PLL_W   = 1,
    parameter int PHASE_W = 8
);
    logic               req_valid;
    logic [PLL_W-1:0]   req_pll;
    logic [PHASE_W-1:0] req_phase;
    logic               req_ready;

    modport master (output req_valid, req_pll, req_phase, input req_ready);
    modport slave  (input req_valid, req_pll, req_phase, output req_ready);
endinterface

// File: rtl/phase_delta_calc.sv
// Forward step count from cur to target, modulo one full rotation.
module phase_delta_calc
    import phase_shift_pkg::*;
#(
    parameter int PHASE_W     = 8,
    parameter int PHASE_STEPS = DEFAULT_PHASE_STEPS
)(
    input  logic [PHASE_W-1:0] i_cur,
    input  logic [PHASE_W-1:0] i_target,
    output logic [PHASE_W-1:0] o_delta,
    output logic               o_zero
);
    localparam logic [PHASE_W:0] STEPS_EXT = (PHASE_W+1)'(PHASE_STEPS);

    logic [PHASE_W:0] w_diff;
    logic [PHASE_W:0] w_mod;

    // One extra bit holds the borrow; a borrow means target is behind cur.
    always_comb begin
        w_diff = {1'b0, i_target} - {1'b0, i_cur};
        w_mod  = w_diff[PHASE_W] ? (w_diff + STEPS_EXT) : w_diff;
    end

    assign o_delta = w_mod[PHASE_W-1:0];
    assign o_zero  = (w_mod == '0);
endmodule

// File: rtl/phase_request_scheduler.sv
// Accepts absolute phase requests per PLL, issues forward step counts to the
// phase_shift_processor one at a time and tracks each PLL's current phase.
module phase_request_scheduler
    import phase_shift_pkg::*;
#(
    parameter int NUM_PLLS      = 2,
    parameter int PHASE_W       = 8,
    parameter int PHASE_STEPS   = DEFAULT_PHASE_STEPS,
    parameter int START_TIMEOUT = 16,
    parameter int PLL_W         = idx_width(NUM_PLLS)
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    phase_request_scheduler_if.slave      s_req,
    output logic [PHASE_W-1:0]            o_periods_to_process,
    output logic [PLL_W-1:0]              o_pll_to_update,
    output logic                          o_ready,
    input  logic [2:0]                    i_shift_state,
    output logic                          o_busy,
    output logic                          o_err_timeout,
    output logic                          o_err_range,
    output logic [NUM_PLLS*PHASE_W-1:0]   o_cur_phase_flat
);
    localparam int              TO_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    sched_state_e       r_state;
    sched_state_e       w_next_state;
    logic [PLL_W-1:0]   r_pll;
    logic [PHASE_W-1:0] r_target;
    logic [PHASE_W-1:0] r_cur_phase [NUM_PLLS];
    logic [PHASE_W-1:0] r_periods;
    logic [PLL_W-1:0]   r_pll_upd;
    logic               r_ready;
    logic               r_issue_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_seen_reset;
    logic               r_err_timeout;
    logic               r_err_range;

    logic [PHASE_W-1:0] w_delta;
    logic               w_zero;
    logic               w_accept;
    logic               w_req_bad;
    logic               w_started;
    logic               w_timed_out;
    logic               w_done;

    assign w_accept    = (r_state == ST_IDLE) && s_req.req_valid;
    assign w_req_bad   = ({1'b0, s_req.req_phase} >= (PHASE_W+1)'(PHASE_STEPS)) ||
                         ({1'b0, s_req.req_pll}   >= (PLL_W+1)'(NUM_PLLS));
    assign w_started   = (i_shift_state != PS_LISTEN);
    assign w_timed_out = !w_started && (r_to_cnt == TO_LAST);
    assign w_done      = r_seen_reset && (i_shift_state == PS_LISTEN);

    phase_delta_calc #(
        .PHASE_W     (PHASE_W),
        .PHASE_STEPS (PHASE_STEPS)
    ) u_delta (
        .i_cur    (r_cur_phase[r_pll]),
        .i_target (r_target),
        .o_delta  (w_delta),
        .o_zero   (w_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept && !w_req_bad) w_next_state = ST_CALC;
            ST_CALC:       w_next_state = w_zero ? ST_IDLE : ST_ISSUE;
            ST_ISSUE:      if (r_issue_cnt) w_next_state = ST_WAIT_START;
            ST_WAIT_START: begin
                if (w_started)        w_next_state = ST_WAIT_DONE;
                else if (w_timed_out) w_next_state = ST_IDLE;
            end
            ST_WAIT_DONE:  if (w_done) w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: the phase table is reset explicitly; after reset every PLL is
    // assumed to be at phase 0 until software re-aligns it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pll         <= '0;
            r_target      <= '0;
            r_periods     <= '0;
            r_pll_upd     <= '0;
            r_ready       <= 1'b0;
            r_issue_cnt   <= 1'b0;
            r_to_cnt      <= '0;
            r_seen_reset  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_range   <= 1'b0;
            for (int i = 0; i < NUM_PLLS; i++) r_cur_phase[i] <= '0;
        end else begin
            r_ready <= (w_next_state == ST_ISSUE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_req_bad) begin
                            r_err_range <= 1'b1;
                        end else begin
                            r_pll    <= s_req.req_pll;
                            r_target <= s_req.req_phase;
                        end
                    end
                end
                ST_CALC: begin
                    r_issue_cnt <= 1'b0;
                    if (!w_zero) begin
                        r_periods <= w_delta;
                        r_pll_upd <= r_pll;
                    end
                end
                ST_ISSUE: begin
                    r_issue_cnt <= 1'b1;
                    r_to_cnt    <= '0;
                end
                ST_WAIT_START: begin
                    r_to_cnt     <= r_to_cnt + 1'b1;
                    r_seen_reset <= 1'b0;
                    if (w_timed_out) r_err_timeout <= 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (i_shift_state == PS_RESET) r_seen_reset <= 1'b1;
                    if (w_done) r_cur_phase[r_pll] <= r_target;
                end
                default: ;
            endcase
        end
    end

    assign s_req.req_ready      = (r_state == ST_IDLE);
    assign o_busy               = (r_state != ST_IDLE);
    assign o_ready              = r_ready;
    assign o_periods_to_process = r_periods;
    assign o_pll_to_update      = r_pll_upd;
    assign o_err_timeout        = r_err_timeout;
    assign o_err_range          = r_err_range;

    for (genvar g = 0; g < NUM_PLLS; g++) begin : g_flat
        assign o_cur_phase_flat[g*PHASE_W +: PHASE_W] = r_cur_phase[g];
    end
endmodule

// File: tb/tb_phase_request_scheduler.sv
// Scenario bench for phase_request_scheduler with a behavioural processor model
// and a scoreboard of expected issued step counts.
module tb_phase_request_scheduler;
    import phase_shift_pkg::*;

    localparam int NUM_PLLS      = 2;
    localparam int PHASE_W       = 8;
    localparam int PHASE_STEPS   = 64;
    localparam int START_TIMEOUT = 16;
    localparam int PLL_W         = 1;
    localparam int FLAT_W        = NUM_PLLS * PHASE_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phase_request_scheduler_if #(.PLL_W(PLL_W), .PHASE_W(PHASE_W)) req_if ();

    logic [PHASE_W-1:0] periods;
    logic [PLL_W-1:0]   pll_upd;
    logic               ready;
    logic [2:0]         shift_state;
    logic               busy;
    logic               err_timeout;
    logic               err_range;
    logic [FLAT_W-1:0]  flat;

    phase_request_scheduler #(
        .NUM_PLLS      (NUM_PLLS),
        .PHASE_W       (PHASE_W),
        .PHASE_STEPS   (PHASE_STEPS),
        .START_TIMEOUT (START_TIMEOUT),
        .PLL_W         (PLL_W)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .s_req                (req_if.slave),
        .o_periods_to_process (periods),
        .o_pll_to_update      (pll_upd),
        .o_ready              (ready),
        .i_shift_state        (shift_state),
        .o_busy               (busy),
        .o_err_timeout        (err_timeout),
        .o_err_range          (err_range),
        .o_cur_phase_flat     (flat)
    );

    // Processor model: negedge-sampled, LISTEN -> SHIFT (n steps) -> VALIDATE -> RESET -> LISTEN.
    logic [2:0] proc_state;
    int         proc_cnt;
    bit         proc_hold = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_state <= PS_LISTEN;
            proc_cnt   <= 0;
        end else begin
            case (proc_state)
                PS_LISTEN: if (ready && !proc_hold) begin
                    proc_state <= PS_SHIFT;
                    proc_cnt   <= int'(periods);
                end
                PS_SHIFT: begin
                    if (proc_cnt <= 1) proc_state <= PS_VALIDATE;
                    else               proc_cnt   <= proc_cnt - 1;
                end
                PS_VALIDATE: proc_state <= PS_RESET;
                PS_RESET:    proc_state <= PS_LISTEN;
                default:     proc_state <= PS_LISTEN;
            endcase
        end
    end
    assign shift_state = proc_state;

    typedef struct {
        int pll;
        int periods;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_item;
    int   model_phase [NUM_PLLS];
    int   total = 0;
    int   bad   = 0;

    function automatic int model_delta(input int cur, input int tgt);
        return (tgt - cur + PHASE_STEPS) % PHASE_STEPS;
    endfunction

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_PLLS; i++) f[i*PHASE_W +: PHASE_W] = PHASE_W'(model_phase[i]);
        return f;
    endfunction

    function automatic exp_t sb_pop();
        exp_t e;
        e.pll = -1;
        e.periods = -1;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    task automatic drive_req(input int pll, input int phase, output bit accepted);
        @(posedge clk); #1;
        req_if.req_valid = 1'b1;
        req_if.req_pll   = PLL_W'(pll);
        req_if.req_phase = PHASE_W'(phase);
        for (int i = 0; i < 500 && !req_if.req_ready; i++) begin
            @(posedge clk); #1;
        end
        accepted = req_if.req_ready;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
    endtask

    task automatic observe_issue(input int bound, output bit seen, output int hi,
                                 output logic [PHASE_W-1:0] per, output logic [PLL_W-1:0] sel);
        seen = 1'b0; hi = 0; per = '0; sel = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            per = periods;
            sel = pll_upd;
            while (ready && hi < 10) begin
                hi++;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_setup(input int pll, input int phase, output bit ok);
        bit acc, seen, idle;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        drive_req(pll, phase, acc);
        observe_issue(20, seen, hi, per, sel);
        wait_idle(400, idle);
        model_phase[pll] = phase;
        ok = acc && seen && idle;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_pll   = '0;
        req_if.req_phase = '0;
        repeat (2) @(negedge clk);
        total++; if (req_if.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_if.req_ready); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (periods !== '0) begin bad++; $display("FAIL reset_periods: got %0d want 0", periods); end
        total++; if (busy !== 1'b0 || err_timeout !== 1'b0 || err_range !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got busy=%b tmo=%b rng=%b want 0 0 0", busy, err_timeout, err_range);
        end
        total++; if (flat !== '0 || pll_upd !== '0) begin bad++; $display("FAIL reset_table: got %0h/%0d want 0/0", flat, pll_upd); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_PLLS; i++) model_phase[i] = 0;
    endtask

    task automatic test_basic_shift();
        bit acc, seen, idle;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        sb_q.push_back('{pll: 0, periods: model_delta(model_phase[0], 5)});
        drive_req(0, 5, acc);
        total++; if (!acc) begin bad++; $display("FAIL basic_accept: got 0 want 1"); end
        total++; if (req_if.req_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy: got req_ready=%b busy=%b want 0 1", req_if.req_ready, busy);
        end
        observe_issue(20, seen, hi, per, sel);
        exp_item = sb_pop();
        total++; if (!seen) begin bad++; $display("FAIL basic_issue_seen: got 0 want 1"); end
        total++; if (per !== PHASE_W'(exp_item.periods)) begin bad++; $display("FAIL basic_periods: got %0d want %0d", per, exp_item.periods); end
        total++; if (sel !== PLL_W'(exp_item.pll)) begin bad++; $display("FAIL basic_pll: got %0d want %0d", sel, exp_item.pll); end
        total++; if (hi != 2) begin bad++; $display("FAIL basic_ready_cycles: got %0d want 2", hi); end
        wait_idle(200, idle);
        model_phase[0] = 5;
        total++; if (!idle) begin bad++; $display("FAIL basic_done: got busy want idle"); end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL basic_table: got %0h want %0h", flat, model_flat()); end
        total++; if (req_if.req_ready !== 1'b1) begin bad++; $display("FAIL basic_req_ready: got %b want 1", req_if.req_ready); end
    endtask

    task automatic test_wrap();
        bit ok, acc, seen, idle;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        run_setup(1, 60, ok);
        total++; if (!ok || flat !== model_flat()) begin bad++; $display("FAIL wrap_setup: got %0h want %0h", flat, model_flat()); end
        sb_q.push_back('{pll: 1, periods: model_delta(model_phase[1], 4)});
        drive_req(1, 4, acc);
        observe_issue(20, seen, hi, per, sel);
        exp_item = sb_pop();
        total++; if (!seen || per !== PHASE_W'(exp_item.periods)) begin bad++; $display("FAIL wrap_periods: got %0d want %0d", per, exp_item.periods); end
        total++; if (sel !== PLL_W'(exp_item.pll)) begin bad++; $display("FAIL wrap_pll: got %0d want %0d", sel, exp_item.pll); end
        wait_idle(200, idle);
        model_phase[1] = 4;
        total++; if (!idle || flat !== model_flat()) begin bad++; $display("FAIL wrap_table: got %0h want %0h", flat, model_flat()); end
    endtask

    task automatic test_zero_delta();
        bit acc, seen;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        drive_req(0, model_phase[0], acc);
        @(posedge clk); #1;
        total++; if (!acc || busy !== 1'b0) begin bad++; $display("FAIL zero_idle: got acc=%b busy=%b want 1 0", acc, busy); end
        observe_issue(10, seen, hi, per, sel);
        total++; if (seen) begin bad++; $display("FAIL zero_no_ready: got pulse want none"); end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL zero_table: got %0h want %0h", flat, model_flat()); end
    endtask

    task automatic test_timeout();
        bit acc, seen, idle, early;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        proc_hold = 1'b1;
        sb_q.push_back('{pll: 0, periods: model_delta(model_phase[0], 20)});
        drive_req(0, 20, acc);
        observe_issue(20, seen, hi, per, sel);
        exp_item = sb_pop();
        total++; if (!seen || per !== PHASE_W'(exp_item.periods)) begin bad++; $display("FAIL tmo_periods: got %0d want %0d", per, exp_item.periods); end
        // Here WAIT_START began at the previous posedge; the flag may rise only START_TIMEOUT edges later.
        early = err_timeout;
        for (int i = 1; i < START_TIMEOUT; i++) begin
            @(negedge clk);
            early = early | err_timeout;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL tmo_early: got 1 want 0"); end
        @(negedge clk);
        total++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL tmo_flag: got tmo=%b busy=%b want 1 0", err_timeout, busy);
        end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL tmo_table: got %0h want %0h", flat, model_flat()); end
        proc_hold = 1'b0;
        sb_q.push_back('{pll: 0, periods: model_delta(model_phase[0], 20)});
        drive_req(0, 20, acc);
        observe_issue(20, seen, hi, per, sel);
        exp_item = sb_pop();
        total++; if (!acc || !seen || per !== PHASE_W'(exp_item.periods)) begin bad++; $display("FAIL tmo_next_periods: got %0d want %0d", per, exp_item.periods); end
        wait_idle(200, idle);
        model_phase[0] = 20;
        total++; if (!idle || flat !== model_flat()) begin bad++; $display("FAIL tmo_next_table: got %0h want %0h", flat, model_flat()); end
    endtask

    task automatic test_range();
        bit acc, seen;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        drive_req(0, 70, acc);
        total++; if (err_range !== 1'b1) begin bad++; $display("FAIL range_flag: got %b want 1", err_range); end
        total++; if (req_if.req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL range_ready: got req_ready=%b busy=%b want 1 0", req_if.req_ready, busy);
        end
        observe_issue(10, seen, hi, per, sel);
        total++; if (seen || flat !== model_flat()) begin bad++; $display("FAIL range_no_issue: got seen=%b tbl=%0h want 0 %0h", seen, flat, model_flat()); end
    endtask

    task automatic test_reset_mid_shift();
        bit acc, seen;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        sb_q.push_back('{pll: 1, periods: model_delta(model_phase[1], 44)});
        drive_req(1, 44, acc);
        observe_issue(20, seen, hi, per, sel);
        exp_item = sb_pop();
        total++; if (!seen || per !== PHASE_W'(exp_item.periods)) begin bad++; $display("FAIL mid_periods: got %0d want %0d", per, exp_item.periods); end
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1 || shift_state !== PS_SHIFT) begin bad++; $display("FAIL mid_in_shift: got busy=%b st=%0d want 1 1", busy, shift_state); end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_PLLS; i++) model_phase[i] = 0;
        total++; if (req_if.req_ready !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ctrl: got rr=%b rdy=%b busy=%b want 1 0 0", req_if.req_ready, ready, busy);
        end
        total++; if (periods !== '0 || pll_upd !== '0) begin bad++; $display("FAIL mid_rst_outs: got %0d/%0d want 0/0", periods, pll_upd); end
        total++; if (err_timeout !== 1'b0 || err_range !== 1'b0) begin bad++; $display("FAIL mid_rst_errs: got %b%b want 00", err_timeout, err_range); end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL mid_rst_table: got %0h want %0h", flat, model_flat()); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit seen, idle;
        int hi;
        logic [PHASE_W-1:0] per;
        logic [PLL_W-1:0] sel;
        sb_q.push_back('{pll: 0, periods: model_delta(model_phase[0], 3)});
        sb_q.push_back('{pll: 1, periods: model_delta(model_phase[1], 9)});
        @(posedge clk); #1;
        req_if.req_valid = 1'b1;
        req_if.req_pll   = PLL_W'(0);
        req_if.req_phase = PHASE_W'(3);
        @(posedge clk); #1;
        req_if.req_pll   = PLL_W'(1);
        req_if.req_phase = PHASE_W'(9);
        total++; if (req_if.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold: got req_ready=%b want 0", req_if.req_ready); end
        observe_issue(20, seen, hi, per, sel);
        exp_item = sb_pop();
        total++; if (!seen || per !== PHASE_W'(exp_item.periods) || sel !== PLL_W'(exp_item.pll)) begin
            bad++; $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", per, sel, exp_item.periods, exp_item.pll);
        end
        observe_issue(100, seen, hi, per, sel);
        req_if.req_valid = 1'b0;
        exp_item = sb_pop();
        total++; if (!seen || per !== PHASE_W'(exp_item.periods) || sel !== PLL_W'(exp_item.pll)) begin
            bad++; $display("FAIL b2b_second: got %0d/%0d want %0d/%0d", per, sel, exp_item.periods, exp_item.pll);
        end
        wait_idle(200, idle);
        model_phase[0] = 3;
        model_phase[1] = 9;
        total++; if (!idle || flat !== model_flat()) begin bad++; $display("FAIL b2b_table: got %0h want %0h", flat, model_flat()); end
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL b2b_scoreboard: got %0d left want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_shift();
        test_wrap();
        test_zero_delta();
        test_timeout();
        test_range();
        test_reset_mid_shift();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
